// File: rtl/ram_access_sequencer.sv
// Front-end sequencer for a single-port registered-output 16-bit RAM: clears it
// after reset or on request, and serialises CPU reads, writes and byte-lane RMWs.
module ram_access_sequencer #(
  parameter int          WIDTHAD = 10,
  parameter logic [15:0] FILL    = 16'h0000,
  parameter int          RD_LAT  = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear_req,
  output logic               busy,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [1:0]         cpu_be,
  input  logic [WIDTHAD-1:0] cpu_addr,
  input  logic [15:0]        cpu_din,
  output logic [15:0]        cpu_dout,
  output logic               cpu_ack,
  output logic [WIDTHAD-1:0] ram_address,
  output logic [15:0]        ram_data,
  output logic               ram_wren,
  input  logic [15:0]        ram_q
);

  localparam int LW = $clog2(RD_LAT + 1) + 1;

  typedef enum logic [2:0] {CLEAR, IDLE, RD_WAIT, ACK_RD, WR_MERGE, ACK} state_t;

  state_t             state;
  logic [WIDTHAD:0]   clr_cnt;
  logic [LW-1:0]      lat_cnt;
  logic               clr_pend;
  logic               we_q;
  logic [1:0]         be_q;
  logic [WIDTHAD-1:0] addr_q;
  logic [15:0]        din_q;
  logic [15:0]        merged;

  // Enabled lanes take the new data, the rest keep what the RAM returned.
  always_comb begin
    merged = {be_q[1] ? din_q[15:8] : ram_q[15:8],
              be_q[0] ? din_q[7:0]  : ram_q[7:0]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= CLEAR;
      clr_cnt     <= '0;
      lat_cnt     <= '0;
      clr_pend    <= 1'b0;
      busy        <= 1'b1;
      cpu_ack     <= 1'b0;
      cpu_dout    <= 16'h0000;
      ram_wren    <= 1'b0;
      ram_address <= '0;
      ram_data    <= FILL;
      we_q        <= 1'b0;
      be_q        <= 2'b00;
      addr_q      <= '0;
      din_q       <= 16'h0000;
    end else begin
      // A request arriving mid-op is parked until the op has acked.
      if (clear_req && state != CLEAR) begin
        clr_pend <= 1'b1;
        busy     <= 1'b1;
      end
      case (state)
        CLEAR: begin
          // Extra counter bit marks the end of the sweep, so wrap cannot cut it short.
          if (clr_cnt[WIDTHAD]) begin
            ram_wren <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            ram_wren    <= 1'b1;
            ram_address <= clr_cnt[WIDTHAD-1:0];
            ram_data    <= FILL;
            clr_cnt     <= clr_cnt + 1'b1;
          end
        end
        IDLE: begin
          ram_wren <= 1'b0;
          cpu_ack  <= 1'b0;
          if (clr_pend || clear_req) begin
            clr_pend <= 1'b0;
            clr_cnt  <= '0;
            busy     <= 1'b1;
            state    <= CLEAR;
          end else if (cpu_req) begin
            we_q    <= cpu_we;
            be_q    <= cpu_be;
            addr_q  <= cpu_addr;
            din_q   <= cpu_din;
            lat_cnt <= '0;
            if (cpu_we && (cpu_be == 2'b11 || cpu_be == 2'b00)) state <= ACK;
            else                                               state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          ram_address <= addr_q;
          ram_wren    <= 1'b0;
          if (lat_cnt == LW'(RD_LAT)) state <= we_q ? WR_MERGE : ACK_RD;
          else                        lat_cnt <= lat_cnt + 1'b1;
        end
        ACK_RD: begin
          cpu_dout <= ram_q;
          cpu_ack  <= 1'b1;
          state    <= IDLE;
        end
        WR_MERGE: begin
          ram_wren <= 1'b1;
          ram_data <= merged;
          cpu_ack  <= 1'b1;
          state    <= IDLE;
        end
        ACK: begin
          // Full-word writes go straight out; an all-lanes-off write only acks.
          ram_wren    <= we_q && (be_q == 2'b11);
          ram_address <= addr_q;
          ram_data    <= din_q;
          cpu_ack     <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_sequencer.sv
// Scoreboard bench for ram_access_sequencer driving a behavioural registered-output RAM.
module tb_ram_access_sequencer;

  localparam int          W    = 4;
  localparam logic [15:0] FILL = 16'hA5A5;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         clear_req = 1'b0;
  logic         busy;
  logic         cpu_req = 1'b0;
  logic         cpu_we = 1'b0;
  logic [1:0]   cpu_be = 2'b00;
  logic [W-1:0] cpu_addr = '0;
  logic [15:0]  cpu_din = 16'h0;
  logic [15:0]  cpu_dout;
  logic         cpu_ack;
  logic [W-1:0] ram_address;
  logic [15:0]  ram_data;
  logic         ram_wren;
  logic [15:0]  ram_q;

  ram_access_sequencer #(.WIDTHAD(W), .FILL(FILL), .RD_LAT(2)) dut (
    .clock(clock), .reset(reset), .clear_req(clear_req), .busy(busy),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Two-stage RAM: address register, then output register.
  logic [15:0]  mem [16];
  logic [W-1:0] addr_r;
  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    addr_r <= ram_address;
    ram_q  <= mem[addr_r];
  end

  int n_vec = 0;
  int n_err = 0;

  typedef struct {logic [W-1:0] a; logic [15:0] d; int c;} wr_t;
  typedef struct {bit rd; logic [15:0] d; int c;} ack_t;
  wr_t  wq[$];
  ack_t aq[$];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: every RAM write and every ack must match the next queued expectation.
  logic busy_p = 1'b1;
  logic wren_p = 1'b0;
  always @(negedge clock) begin
    wr_t  e;
    ack_t x;
    if (ram_wren === 1'b1) begin
      if (wq.size() == 0) chk("unexpected_wren", {28'h0, ram_address}, 32'hFFFFFFFF);
      else begin
        e = wq.pop_front();
        chk("wr_addr", 32'(ram_address), 32'(e.a));
        chk("wr_data", 32'(ram_data), 32'(e.d));
        if (e.c >= 0) chk("wr_cycle", cyc, e.c);
      end
    end
    if (cpu_ack === 1'b1) begin
      if (aq.size() == 0) chk("unexpected_ack", 1, 0);
      else begin
        x = aq.pop_front();
        if (x.c >= 0) chk("ack_cycle", cyc, x.c);
        if (x.rd) chk("rd_data", 32'(cpu_dout), 32'(x.d));
      end
    end
    if (busy_p === 1'b1 && busy === 1'b0) chk("busy_wren_fall", {30'h0, wren_p, ram_wren}, 32'h2);
    busy_p = busy;
    wren_p = ram_wren;
  end

  task automatic chk_reset();
    chk("rst_busy", 32'(busy), 1);
    chk("rst_ack", 32'(cpu_ack), 0);
    chk("rst_dout", 32'(cpu_dout), 0);
    chk("rst_wren", 32'(ram_wren), 0);
    chk("rst_addr", 32'(ram_address), 0);
    chk("rst_data", 32'(ram_data), 32'(FILL));
  endtask

  task automatic push_clear(input int c0);
    for (int i = 0; i < 16; i++) wq.push_back('{W'(i), FILL, (c0 < 0) ? -1 : c0 + 1 + i});
  endtask

  task automatic wait_not_busy(input int exp_c);
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clock);
      if (busy === 1'b0) done = 1;
    end
    chk("clear_done", 32'(done), 1);
    if (done && exp_c >= 0) chk("clear_end_cycle", cyc, exp_c);
  endtask

  task automatic wait_ack(input bit scramble, output bit got);
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clock);
      #1;
      if (cpu_ack === 1'b1) got = 1;
      if (scramble && i == 0) begin
        cpu_addr = ~cpu_addr;
        cpu_din  = ~cpu_din;
      end
    end
    if (!got) chk("ack_timeout", 0, 1);
  endtask

  // lat = expected E0-to-ack edges (0 when the DUT may be busy at request time).
  task automatic cpu_op(input bit we, input logic [1:0] be, input logic [W-1:0] a,
                        input logic [15:0] d, input logic [15:0] exp_d,
                        input int lat, input bit after_clear);
    int c0;
    int ec;
    bit got;
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = we; cpu_be = be; cpu_addr = a; cpu_din = d;
    c0 = cyc;
    ec = (lat > 0) ? c0 + 1 + lat : -1;
    if (!we) aq.push_back('{1'b1, exp_d, ec});
    else begin
      aq.push_back('{1'b0, 16'h0, ec});
      if (be == 2'b11)      wq.push_back('{a, d, ec});
      else if (be != 2'b00) wq.push_back('{a, exp_d, ec});
    end
    wait_ack(lat > 0, got);
    if (got && after_clear) chk("ack_after_clear", 32'(busy), 0);
    cpu_req = 1'b0;
  endtask

  initial begin
    int c0;
    bit got;

    // Reset values, then the power-on sweep.
    repeat (3) @(negedge clock);
    chk_reset();
    c0 = cyc;
    push_clear(c0);
    reset = 1'b0;
    wait_not_busy(c0 + 17);

    // Full-word write/read, byte-lane RMWs, and an all-lanes-off write.
    cpu_op(1'b1, 2'b11, 4'd3, 16'h1234, 16'h0000, 1, 1'b0);
    cpu_op(1'b0, 2'b00, 4'd3, 16'h0000, 16'h1234, 4, 1'b0);
    cpu_op(1'b1, 2'b10, 4'd5, 16'hBEEF, 16'hBEA5, 4, 1'b0);
    cpu_op(1'b0, 2'b00, 4'd5, 16'h0000, 16'hBEA5, 4, 1'b0);
    cpu_op(1'b1, 2'b01, 4'd5, 16'hBEEF, 16'hBEEF, 4, 1'b0);
    cpu_op(1'b0, 2'b00, 4'd5, 16'h0000, 16'hBEEF, 4, 1'b0);
    cpu_op(1'b1, 2'b01, 4'd5, 16'h3C5A, 16'hBE5A, 4, 1'b0);
    cpu_op(1'b1, 2'b00, 4'd5, 16'h0000, 16'h0000, 1, 1'b0);
    cpu_op(1'b0, 2'b00, 4'd5, 16'h0000, 16'hBE5A, 4, 1'b0);

    // Clear requested while a read is in flight: read finishes first.
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 2'b00; cpu_addr = 4'd3;
    c0 = cyc;
    aq.push_back('{1'b1, 16'h1234, c0 + 5});
    push_clear(-1);
    @(negedge clock); clear_req = 1'b1;
    @(negedge clock); clear_req = 1'b0;
    wait_ack(1'b0, got);
    cpu_req = 1'b0;
    chk("busy_at_rd_ack", 32'(busy), 1);
    cpu_op(1'b1, 2'b11, 4'd7, 16'h7777, 16'h0000, 0, 1'b1);
    cpu_op(1'b0, 2'b00, 4'd7, 16'h0000, 16'h7777, 4, 1'b0);
    cpu_op(1'b0, 2'b00, 4'd3, 16'h0000, FILL, 4, 1'b0);

    // Simultaneous clear and CPU write in IDLE: clear first, write survives.
    @(negedge clock);
    clear_req = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 2'b11; cpu_addr = 4'd9; cpu_din = 16'h9999;
    push_clear(-1);
    wq.push_back('{4'd9, 16'h9999, -1});
    aq.push_back('{1'b0, 16'h0, -1});
    @(negedge clock); clear_req = 1'b0;
    wait_ack(1'b0, got);
    if (got) chk("ack_after_clear", 32'(busy), 0);
    cpu_req = 1'b0;
    cpu_op(1'b0, 2'b00, 4'd9, 16'h0000, 16'h9999, 4, 1'b0);
    cpu_op(1'b0, 2'b00, 4'd7, 16'h0000, FILL, 4, 1'b0);

    // Reset during RD_WAIT: no ack, reset values, fresh sweep.
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 2'b00; cpu_addr = 4'd9;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1; cpu_req = 1'b0;
    @(negedge clock);
    chk_reset();
    @(negedge clock);
    c0 = cyc;
    push_clear(c0);
    reset = 1'b0;
    wait_not_busy(c0 + 17);
    cpu_op(1'b0, 2'b00, 4'd9, 16'h0000, FILL, 4, 1'b0);

    repeat (5) @(negedge clock);
    chk("wr_queue_empty", wq.size(), 0);
    chk("ack_queue_empty", aq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
